instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch-stage sequencer for the 16-bit-word instruction memory; the memory has a combinational read.
- Drives the memory address (MAR) and samples the read data (MDR) in the same cycle.
- Assembles one-word and two-word (opcode + immediate) instructions and hands them to decode with a valid flag.
- Loads the boot PC from a reset vector in memory, supports pipeline stall and branch/jump redirect, and sits between the PC logic and the IF/ID register.

Parameters:
- WORD_LENGTH, 16, instruction memory word width.
- ADDRESS_SPACE, 21, instruction memory address width; PC width.
- IMM_FLAG_BIT, 0, bit of the first instruction word that, when 1, marks a two-word instruction.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mar  output  ADDRESS_SPACE  address to instruction memory (combinational from internal fetch PC).
- mdr  input  WORD_LENGTH  read data from instruction memory, valid in the same cycle as mar.
- stall  input  1  hazard unit freeze request.
- redirect  input  1  taken branch/jump/interrupt redirect.
- redirect_pc  input  ADDRESS_SPACE  redirect target.
- ir  output  WORD_LENGTH  instruction word to decode.
- imm  output  WORD_LENGTH  immediate word; 0 for one-word instructions.
- pc_out  output  ADDRESS_SPACE  address of the first word of the instruction in ir.
- if_valid  output  1  ir/imm/pc_out hold a valid instruction this cycle.

Behaviour:
- Reset (asynchronous, reset=0):
  - Internal fetch PC, pending word and pending PC are 0.
  - ir=0, imm=0, pc_out=0, if_valid=0, state=BOOT_HI.
  - mar=0 while in reset.
- FSM states: BOOT_HI, BOOT_LO, FETCH, FETCH_IMM. mar always equals the fetch PC, except in BOOT_HI (mar=0) and BOOT_LO (mar=1).
- BOOT_HI:
  - Latch mdr[ADDRESS_SPACE-WORD_LENGTH-1:0] (5 bits at defaults) as the upper PC bits.
  - Next state BOOT_LO. if_valid stays 0.
- BOOT_LO:
  - fetch PC <= {upper bits, mdr}. Next state FETCH. if_valid stays 0.
  - Boot therefore takes exactly 2 cycles after reset deassertion; the first instruction is valid on the 3rd edge.
  - stall and redirect are ignored in both boot states.
- FETCH, mdr[IMM_FLAG_BIT]=0:
  - ir<=mdr, imm<=0, pc_out<=PC, if_valid<=1, PC<=PC+1.
  - Stay in FETCH. Throughput is 1 instruction/cycle.
- FETCH, mdr[IMM_FLAG_BIT]=1:
  - pending word<=mdr, pending PC<=PC, PC<=PC+1, if_valid<=0.
  - Next state FETCH_IMM.
- FETCH_IMM:
  - ir<=pending word, imm<=mdr, pc_out<=pending PC, if_valid<=1, PC<=PC+1.
  - Next state FETCH.
- Stall (stall=1, no redirect, not booting):
  - All registers hold: PC, state, ir, imm, pc_out, if_valid, pending.
  - mar is unchanged, so the same word is re-read on release.
- Redirect (redirect=1, not booting), takes priority over stall:
  - PC<=redirect_pc, state<=FETCH, if_valid<=0.
  - A pending first word is discarded. ir/imm/pc_out hold their values.
  - The first target instruction is valid 1 cycle after the redirect edge for one-word instructions, 2 cycles for two-word.
- Arithmetic: PC+1 is modulo 2^ADDRESS_SPACE, so 0x1FFFFF wraps to 0x000000. This also applies to the immediate fetch of a two-word instruction starting at 0x1FFFFF, whose imm is read from address 0.
- Reset asserted mid-operation (any state, including FETCH_IMM) immediately returns all outputs to their reset values. Boot restarts on release.

Test Plan:
- Boot vector: mem[0]=0x0001, mem[1]=0x0040, release reset → mar=0 then 1; on the 3rd edge mar=0x010040 and if_valid=1 with ir=mem[0x010040].
- Straight-line one-word: mem[0x40..0x42]=0x1000,0x2000,0x3000 (bit0=0), no stall → on 3 consecutive edges ir=0x1000/0x2000/0x3000, pc_out=0x40/0x41/0x42, imm=0, if_valid=1 each cycle.
- Two-word: mem[0x40]=0x1001, mem[0x41]=0xBEEF → after the first edge if_valid=0; after the second edge ir=0x1001, imm=0xBEEF, pc_out=0x40, if_valid=1; the next fetch is from mar=0x42.
- Stall: assert stall for 3 cycles while ir=0x2000 is valid → ir/pc_out/mar are frozen and if_valid stays 1; on release, ir=0x3000 on the next edge.
- Redirect: in FETCH_IMM (pending 0x1001) assert redirect=1, redirect_pc=0x100, and stall=1 together → next cycle if_valid=0 and mar=0x100; the pending word never appears on ir; ir=mem[0x100] one edge later.
- Wrap and reset: PC=0x1FFFFF holding a one-word instruction → next mar=0x000000. Assert reset in FETCH_IMM → outputs return to 0 asynchronously and mar=0.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer.
// Reads the boot PC from the reset vector at addresses 0/1. It then walks the
// instruction memory and assembles one-word and two-word (opcode + immediate)
// instructions for decode. Stall freezes everything. Redirect restarts fetch
// at a new target and drops any half-assembled instruction.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BOOT_HI   | reading address 0, latching the upper PC bits of the vector
// BOOT_LO   | reading address 1, forming the boot PC
// FETCH     | reading the first word of an instruction at the fetch PC
// FETCH_IMM | first word held as pending, reading its immediate word

module instr_fetch_ctrl #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 21,
    parameter int IMM_FLAG_BIT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_SPACE-1:0] mar,
    input  logic [WORD_LENGTH-1:0]   mdr,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_SPACE-1:0] redirect_pc,
    output logic [WORD_LENGTH-1:0]   ir,
    output logic [WORD_LENGTH-1:0]   imm,
    output logic [ADDRESS_SPACE-1:0] pc_out,
    output logic                     if_valid
);

    // The reset vector word at address 0 supplies the PC bits above one memory word.
    localparam int UPPER_W = ADDRESS_SPACE - WORD_LENGTH;

    localparam logic [1:0] BOOT_HI   = 2'd0;
    localparam logic [1:0] BOOT_LO   = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] FETCH_IMM = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [ADDRESS_SPACE-1:0] fetch_pc;
    logic [ADDRESS_SPACE-1:0] fetch_pc_nxt;
    logic [ADDRESS_SPACE-1:0] fetch_pc_inc;
    logic [UPPER_W-1:0]       boot_upper;
    logic [UPPER_W-1:0]       boot_upper_nxt;
    logic [WORD_LENGTH-1:0]   pend_word;
    logic [WORD_LENGTH-1:0]   pend_word_nxt;
    logic [ADDRESS_SPACE-1:0] pend_pc;
    logic [ADDRESS_SPACE-1:0] pend_pc_nxt;
    logic [WORD_LENGTH-1:0]   ir_nxt;
    logic [WORD_LENGTH-1:0]   imm_nxt;
    logic [ADDRESS_SPACE-1:0] pc_out_nxt;
    logic                     if_valid_nxt;
    logic                     imm_flag;

    // Natural-width add, so the fetch PC wraps from all-ones to zero.
    assign fetch_pc_inc = fetch_pc + ADDRESS_SPACE'(1);
    assign imm_flag     = mdr[IMM_FLAG_BIT];

    // Memory address: fixed vector locations during boot, fetch PC afterwards.
    always_comb begin
        case (state)
            BOOT_HI: mar = '0;
            BOOT_LO: mar = ADDRESS_SPACE'(1);
            default: mar = fetch_pc;
        endcase
    end

    // Next-state and datapath decisions; every register holds unless told otherwise.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        boot_upper_nxt = boot_upper;
        pend_word_nxt  = pend_word;
        pend_pc_nxt    = pend_pc;
        ir_nxt         = ir;
        imm_nxt        = imm;
        pc_out_nxt     = pc_out;
        if_valid_nxt   = if_valid;

        case (state)
            BOOT_HI: begin
                boot_upper_nxt = mdr[UPPER_W-1:0];
                state_nxt      = BOOT_LO;
            end
            BOOT_LO: begin
                fetch_pc_nxt = {boot_upper, mdr};
                state_nxt    = FETCH;
            end
            default: begin
                if (redirect) begin
                    // Redirect wins over stall. A pending first word is simply
                    // forgotten, because FETCH never looks at it again.
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = FETCH;
                    if_valid_nxt = 1'b0;
                end else if (!stall) begin
                    fetch_pc_nxt = fetch_pc_inc;
                    if (state == FETCH_IMM) begin
                        ir_nxt       = pend_word;
                        imm_nxt      = mdr;
                        pc_out_nxt   = pend_pc;
                        if_valid_nxt = 1'b1;
                        state_nxt    = FETCH;
                    end else if (imm_flag) begin
                        pend_word_nxt = mdr;
                        pend_pc_nxt   = fetch_pc;
                        if_valid_nxt  = 1'b0;
                        state_nxt     = FETCH_IMM;
                    end else begin
                        ir_nxt       = mdr;
                        imm_nxt      = '0;
                        pc_out_nxt   = fetch_pc;
                        if_valid_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // Sequencer state: FSM, fetch PC, boot vector upper bits, pending first word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT_HI;
            fetch_pc   <= '0;
            boot_upper <= '0;
            pend_word  <= '0;
            pend_pc    <= '0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            boot_upper <= boot_upper_nxt;
            pend_word  <= pend_word_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    // Decode-facing output register (IF/ID handoff).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir       <= '0;
            imm      <= '0;
            pc_out   <= '0;
            if_valid <= 1'b0;
        end else begin
            ir       <= ir_nxt;
            imm      <= imm_nxt;
            pc_out   <= pc_out_nxt;
            if_valid <= if_valid_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl.
// Directed scenarios first, then randomized stall/redirect/reset traffic.
// The DUT is compared against an instruction-stream reference model.

module tb_instr_fetch_ctrl;

    localparam int AW = 21;
    localparam int WW = 16;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] mar;
    logic [WW-1:0] mdr;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [WW-1:0] ir;
    logic [WW-1:0] imm;
    logic [AW-1:0] pc_out;
    logic          if_valid;

    logic [WW-1:0] mem [0:MEM_WORDS-1];

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .mar         (mar),
        .mdr         (mdr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .imm         (imm),
        .pc_out      (pc_out),
        .if_valid    (if_valid)
    );

    // Combinational-read instruction memory.
    assign mdr = mem[mar];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The model is an instruction stream: a next-read address, an optional
    // half-built instruction, and the last instruction handed to decode.
    typedef struct {
        logic [WW-1:0] word;
        logic [AW-1:0] addr;
    } first_t;

    int            boot_left;
    logic [AW-1:0] m_pc;
    logic [WW-1:0] m_ir;
    logic [WW-1:0] m_imm;
    logic [AW-1:0] m_pco;
    logic          m_valid;
    first_t        pend_q[$];

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return AW'((int'(a) + 1) % MEM_WORDS);
    endfunction

    task automatic model_reset();
        boot_left = 2;
        m_pc      = '0;
        m_ir      = '0;
        m_imm     = '0;
        m_pco     = '0;
        m_valid   = 1'b0;
        pend_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [AW-1:0] rpc);
        logic [WW-1:0] w;
        first_t        f;
        if (boot_left == 2) begin
            boot_left = 1;
        end else if (boot_left == 1) begin
            m_pc      = {mem[0][AW-WW-1:0], mem[1]};
            boot_left = 0;
        end else if (r) begin
            m_pc    = rpc;
            m_valid = 1'b0;
            pend_q.delete();
        end else if (!s) begin
            w = mem[m_pc];
            if (pend_q.size() != 0) begin
                f       = pend_q.pop_front();
                m_ir    = f.word;
                m_imm   = w;
                m_pco   = f.addr;
                m_valid = 1'b1;
            end else if (w[0]) begin
                f.word  = w;
                f.addr  = m_pc;
                pend_q.push_back(f);
                m_valid = 1'b0;
            end else begin
                m_ir    = w;
                m_imm   = '0;
                m_pco   = m_pc;
                m_valid = 1'b1;
            end
            m_pc = next_addr(m_pc);
        end
    endtask

    function automatic logic [AW-1:0] exp_mar();
        if (boot_left == 2) return '0;
        if (boot_left == 1) return AW'(1);
        return m_pc;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("mar",      32'(mar),      32'(exp_mar()));
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("ir",       32'(ir),       32'(m_ir));
        chk("imm",      32'(imm),      32'(m_imm));
        chk("pc_out",   32'(pc_out),   32'(m_pco));
    endtask

    // ---------------- stimulus helpers (enter and leave at negedge) ----------------
    task automatic step(input logic s, input logic r, input logic [AW-1:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, r, rpc);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic restart();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_mar", 32'(mar), 32'h0);
        @(negedge clk);
        check_all();
        reset = 1'b1;
    endtask

    task automatic set_vector(input logic [AW-1:0] pc);
        mem[0] = WW'(pc >> WW);
        mem[1] = pc[WW-1:0];
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic          s;
        logic          r;
        logic [AW-1:0] rpc;

        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = WW'($urandom);
        @(negedge clk);

        // Boot vector 0x010040.
        mem[0]        = 16'h0001;
        mem[1]        = 16'h0040;
        mem[21'h010040] = 16'h7770;
        restart();
        chk("boot_mar0", 32'(mar), 32'h0);
        step(1'b1, 1'b1, 21'h00AAAA);          // boot ignores stall/redirect
        chk("boot_mar1", 32'(mar), 32'h1);
        step(1'b0, 1'b0, '0);
        chk("boot_mar2", 32'(mar), 32'h010040);
        chk("boot_nv", 32'(if_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("boot_ir", 32'(ir), 32'h7770);
        chk("boot_pc", 32'(pc_out), 32'h010040);
        chk("boot_v", 32'(if_valid), 32'h1);

        // Straight-line one-word instructions with a 3-cycle stall.
        set_vector(21'h000040);
        mem[21'h40] = 16'h1000;
        mem[21'h41] = 16'h2000;
        mem[21'h42] = 16'h3000;
        mem[21'h43] = 16'h4000;
        restart();
        run(3);
        chk("sl_ir0", 32'(ir), 32'h1000);
        chk("sl_pc0", 32'(pc_out), 32'h40);
        step(1'b0, 1'b0, '0);
        chk("sl_ir1", 32'(ir), 32'h2000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            chk("stall_ir", 32'(ir), 32'h2000);
            chk("stall_pc", 32'(pc_out), 32'h41);
            chk("stall_mar", 32'(mar), 32'h42);
            chk("stall_v", 32'(if_valid), 32'h1);
        end
        step(1'b0, 1'b0, '0);
        chk("sl_ir2", 32'(ir), 32'h3000);
        chk("sl_imm", 32'(imm), 32'h0);

        // Two-word instruction, then redirect+stall while an opcode is pending.
        mem[21'h40]  = 16'h1001;
        mem[21'h41]  = 16'hBEEF;
        mem[21'h42]  = 16'h1001;
        mem[21'h43]  = 16'h2222;
        mem[21'h100] = 16'h5550;
        restart();
        run(3);
        chk("tw_nv", 32'(if_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("tw_ir", 32'(ir), 32'h1001);
        chk("tw_imm", 32'(imm), 32'hBEEF);
        chk("tw_pc", 32'(pc_out), 32'h40);
        chk("tw_mar", 32'(mar), 32'h42);
        step(1'b0, 1'b0, '0);                  // opcode at 0x42 now pending
        step(1'b1, 1'b1, 21'h100);
        chk("rd_nv", 32'(if_valid), 32'h0);
        chk("rd_mar", 32'(mar), 32'h100);
        chk("rd_hold", 32'(pc_out), 32'h40);
        step(1'b0, 1'b0, '0);
        chk("rd_ir", 32'(ir), 32'h5550);
        chk("rd_pc", 32'(pc_out), 32'h100);

        // Wrap at the top of the address space, one-word.
        set_vector(21'h1FFFFF);
        mem[21'h1FFFFF] = 16'h6660;
        restart();
        run(3);
        chk("wrap_pc", 32'(pc_out), 32'h1FFFFF);
        chk("wrap_mar", 32'(mar), 32'h0);
        run(4);

        // Two-word straddling the wrap; imm comes from address 0. Then reset in FETCH_IMM.
        mem[21'h1FFFFF] = 16'h6661;
        restart();
        run(4);
        chk("wrap2_ir", 32'(ir), 32'h6661);
        chk("wrap2_imm", 32'(imm), 32'h001F);
        chk("wrap2_pc", 32'(pc_out), 32'h1FFFFF);
        step(1'b0, 1'b0, '0);                  // mem[1]=0xFFFF has the flag set
        chk("wrap2_nv", 32'(if_valid), 32'h0);
        restart();
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_pc", 32'(pc_out), 32'h0);
        run(6);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < MEM_WORDS; i += 4099) mem[i] = WW'($urandom);
        restart();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                restart();
            end else begin
                s = ($urandom_range(0, 99) < 20);
                r = ($urandom_range(0, 99) < 7);
                if ($urandom_range(0, 3) == 0)
                    rpc = AW'(21'h1FFFFF - AW'($urandom_range(0, 2)));
                else
                    rpc = AW'($urandom);
                step(s, r, rpc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
